grant_burst_xfer: RTL and testbench

Downstream data stage for the 4-requester round-robin arbiter. It consumes the arbiter's one-hot `GRANT` and moves a fixed-length burst of words from the granted requester onto a single shared output port. When the burst completes it returns a one-cycle `ACK` to the arbiter, so the arbiter can rotate to the next requester before its time-out expires. If the arbiter withdraws the grant mid-burst (time-out), the burst is aborted cleanly.

---
 rtl/grant_burst_xfer_pkg.sv | 17 +
 rtl/grant_burst_xfer_if.sv | 25 ++
 rtl/grant_burst_xfer_decode.sv | 15 +
 rtl/grant_burst_xfer.sv | 133 +++++++++++++
 tb/tb_grant_burst_xfer.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/grant_burst_xfer_pkg.sv
// Shared constants and helpers for the grant-driven burst transfer stage.
package grant_xfer_pkg;

   // FSM encoding kept as plain 2-bit constants for compatibility with older tools.
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_XFER = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Width of the accepted-word counter; holds BURST_LEN up to 15.
   localparam int CNT_W = 4;

   // Index of a one-hot 4-bit grant. The result is meaningless for non-one-hot input.
   function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
      return {oh[3] | oh[2], oh[3] | oh[1]};
   endfunction

endpackage

// File: rtl/grant_burst_xfer_if.sv
// Handshake and data bundle between the arbiter/requesters and the burst stage.
interface grant_burst_xfer_if #(parameter int DW = 8);
   logic [3:0]      grant;
   logic [4*DW-1:0] din;
   logic [3:0]      valid;
   logic [3:0]      rdy;
   logic [DW-1:0]   dout;
   logic            dout_valid;
   logic [1:0]      dout_src;
   logic            ack;
   logic            abort;
   logic            err;

   // Arbiter and requester side.
   modport master (
      output grant, din, valid,
      input  rdy, dout, dout_valid, dout_src, ack, abort, err
   );

   // Burst transfer stage side.
   modport slave (
      input  grant, din, valid,
      output rdy, dout, dout_valid, dout_src, ack, abort, err
   );
endinterface

// File: rtl/grant_burst_xfer_decode.sv
// Combinational classification of a 4-bit grant vector.
module grant_decode
   import grant_xfer_pkg::*;
(
   input  logic [3:0] grant_i,
   output logic       is_onehot_o,
   output logic [1:0] idx_o,
   output logic       is_zero_o
);

   assign is_zero_o   = (grant_i == 4'b0000);
   assign is_onehot_o = !is_zero_o && ((grant_i & (grant_i - 4'd1)) == 4'b0000);
   assign idx_o       = onehot_to_idx(grant_i);

endmodule

// File: rtl/grant_burst_xfer.sv
// Moves a fixed-length burst from the granted requester to one shared output
// port and acknowledges completion back to the round-robin arbiter.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | waiting for a one-hot grant; flags malformed grants with err
//   XFER    | accepting words from the latched requester; aborts on grant loss
//   DONE    | one cycle, ack high alongside the last word's dout_valid
module grant_burst_xfer
   import grant_xfer_pkg::*;
#(
   parameter int DW        = 8,
   parameter int BURST_LEN = 4
)(
   input  logic               clk_i,
   input  logic               sclr_n_i,
   grant_burst_xfer_if.slave  bus
);

   logic [1:0]       state_q, state_d;
   logic [3:0]       gnt_q, gnt_d;
   logic [1:0]       src_q, src_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [DW-1:0]    dout_q, dout_d;
   logic [1:0]       dout_src_q, dout_src_d;
   logic             dout_valid_q, dout_valid_d;
   logic             abort_q, abort_d;
   logic             err_q, err_d;

   logic             is_onehot_w;
   logic             is_zero_w;
   logic [1:0]       idx_w;
   logic [3:0]       rdy_w;
   logic             grant_lost_w;
   logic             accept_w;
   logic             last_w;
   logic [DW-1:0]    lane_w;

   grant_decode u_decode (
      .grant_i     (bus.grant),
      .is_onehot_o (is_onehot_w),
      .idx_o       (idx_w),
      .is_zero_o   (is_zero_w)
   );

   // Ready only while the arbiter still holds the latched grant, so a
   // withdrawn grant can never coincide with a final accept.
   assign grant_lost_w = (bus.grant != gnt_q);
   assign rdy_w        = (state_q == ST_XFER && !grant_lost_w) ? gnt_q : 4'b0000;
   assign accept_w     = |(rdy_w & bus.valid);
   assign last_w       = (cnt_q == CNT_W'(BURST_LEN - 1));
   assign lane_w       = bus.din[src_q*DW +: DW];

   // Next-state and output-register computation.
   always_comb begin
      state_d      = state_q;
      gnt_d        = gnt_q;
      src_d        = src_q;
      cnt_d        = cnt_q;
      dout_d       = dout_q;
      dout_src_d   = dout_src_q;
      dout_valid_d = 1'b0;
      abort_d      = 1'b0;
      err_d        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (is_onehot_w) begin
               gnt_d   = bus.grant;
               src_d   = idx_w;
               cnt_d   = '0;
               state_d = ST_XFER;
            end else if (!is_zero_w) begin
               err_d = 1'b1;
            end
         end
         ST_XFER: begin
            if (grant_lost_w) begin
               state_d = ST_IDLE;
               abort_d = 1'b1;
               cnt_d   = '0;
            end else if (accept_w) begin
               dout_d       = lane_w;
               dout_src_d   = src_q;
               dout_valid_d = 1'b1;
               cnt_d        = cnt_q + CNT_W'(1);
               if (last_w) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous active-low clear.
   always_ff @(posedge clk_i) begin
      if (!sclr_n_i) begin
         state_q      <= ST_IDLE;
         gnt_q        <= '0;
         src_q        <= '0;
         cnt_q        <= '0;
         dout_q       <= '0;
         dout_src_q   <= '0;
         dout_valid_q <= 1'b0;
         abort_q      <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         gnt_q        <= gnt_d;
         src_q        <= src_d;
         cnt_q        <= cnt_d;
         dout_q       <= dout_d;
         dout_src_q   <= dout_src_d;
         dout_valid_q <= dout_valid_d;
         abort_q      <= abort_d;
         err_q        <= err_d;
      end
   end

   assign bus.rdy        = rdy_w;
   assign bus.dout       = dout_q;
   assign bus.dout_src   = dout_src_q;
   assign bus.dout_valid = dout_valid_q;
   assign bus.ack        = (state_q == ST_DONE);
   assign bus.abort      = abort_q;
   assign bus.err        = err_q;

endmodule

// File: tb/tb_grant_burst_xfer.sv
// Directed bench for grant_burst_xfer: full bursts, gappy valid, grant loss,
// malformed grant, mid-burst reset, and a rotating-grant run with BURST_LEN=2.
module tb_grant_burst_xfer;

   logic clk = 1'b0;
   logic sclr_n;
   int   ncmp  = 0;
   int   nfail = 0;

   grant_burst_xfer_if #(.DW(8)) bus  ();
   grant_burst_xfer_if #(.DW(8)) bus2 ();

   logic       chk_onehot;
   logic       chk_zero;
   logic [1:0] chk_idx;
   logic [1:0] src_log [8];
   int         nlog;

   always #5 clk = ~clk;

   grant_burst_xfer #(.DW(8), .BURST_LEN(4)) u_dut (
      .clk_i    (clk),
      .sclr_n_i (sclr_n),
      .bus      (bus)
   );

   grant_burst_xfer #(.DW(8), .BURST_LEN(2)) u_dut2 (
      .clk_i    (clk),
      .sclr_n_i (sclr_n),
      .bus      (bus2)
   );

   grant_decode u_chk (
      .grant_i     (bus2.grant),
      .is_onehot_o (chk_onehot),
      .idx_o       (chk_idx),
      .is_zero_o   (chk_zero)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Packed {dout_valid, ack, abort, err}.
   task automatic flags(input string tag, input logic [3:0] exp);
      check({tag, ".v_ack_abt_err"},
            32'({bus.dout_valid, bus.ack, bus.abort, bus.err}), 32'(exp));
   endtask

   task automatic word(input string tag, input logic [7:0] d, input logic [1:0] s,
                       input logic last);
      check({tag, ".dout"}, 32'(bus.dout), 32'(d));
      check({tag, ".src"}, 32'(bus.dout_src), 32'(s));
      flags(tag, last ? 4'b1100 : 4'b1000);
   endtask

   task automatic set_lane(input int i, input logic [7:0] v);
      bus.din[i*8 +: 8] = v;
   endtask

   initial begin
      int   nv;
      int   na;
      int   r;
      logic pend;

      sclr_n     = 1'b0;
      bus.grant  = 4'b0000;
      bus.valid  = 4'b0000;
      bus.din    = '0;
      bus2.grant = 4'b0000;
      bus2.valid = 4'b0000;
      bus2.din   = '0;
      tick;
      tick;

      // Reset values
      check("rst.dout", 32'(bus.dout), 32'h0);
      check("rst.src", 32'(bus.dout_src), 32'h0);
      flags("rst", 4'b0000);
      check("rst.rdy", 32'(bus.rdy), 32'h0);
      sclr_n = 1'b1;

      // Full burst from requester 1
      bus.grant = 4'b0010;
      bus.valid = 4'b0010;
      set_lane(1, 8'h10);
      #1;
      check("t1.rdy_idle", 32'(bus.rdy), 32'h0);
      tick;
      check("t1.rdy_xfer", 32'(bus.rdy), 32'h2);
      for (int k = 0; k < 4; k++) begin
         set_lane(1, 8'h10 + 8'(k));
         tick;
         word($sformatf("t1.w%0d", k), 8'h10 + 8'(k), 2'd1, k == 3);
      end
      check("t1.rdy_done", 32'(bus.rdy), 32'h0);
      bus.grant = 4'b0000;
      bus.valid = 4'b0000;
      tick;
      flags("t1.idle", 4'b0000);

      // Requester 0 with toggling valid
      bus.grant = 4'b0001;
      bus.valid = 4'b0001;
      tick;
      nv = 0;
      na = 0;
      for (int c = 0; c < 7; c++) begin
         bus.valid = {3'b000, (c % 2) == 0};
         set_lane(0, 8'h20 + 8'(c));
         #1;
         check($sformatf("t2.rdy%0d", c), 32'(bus.rdy), 32'h1);
         tick;
         nv += int'(bus.dout_valid);
         na += int'(bus.ack);
      end
      check("t2.nvalid", 32'(nv), 32'd4);
      check("t2.nack", 32'(na), 32'd1);
      check("t2.lastdout", 32'(bus.dout), 32'h26);
      bus.grant = 4'b0000;
      bus.valid = 4'b0000;
      tick;
      flags("t2.idle", 4'b0000);

      // Grant withdrawn after two words, then a new burst from requester 3
      bus.grant = 4'b0100;
      bus.valid = 4'b0100;
      tick;
      for (int k = 0; k < 2; k++) begin
         set_lane(2, 8'h30 + 8'(k));
         tick;
         word($sformatf("t3.w%0d", k), 8'h30 + 8'(k), 2'd2, 1'b0);
      end
      bus.grant = 4'b1000;
      bus.valid = 4'b1100;
      set_lane(3, 8'h40);
      #1;
      check("t3.rdy_lost", 32'(bus.rdy), 32'h0);
      tick;
      flags("t3.abort", 4'b0010);
      check("t3.dout_hold", 32'(bus.dout), 32'h31);
      check("t3.rdy_idle", 32'(bus.rdy), 32'h0);
      tick;
      flags("t3.xfer", 4'b0000);
      check("t3.rdy_xfer", 32'(bus.rdy), 32'h8);
      for (int k = 0; k < 4; k++) begin
         set_lane(3, 8'h40 + 8'(k));
         tick;
         word($sformatf("t3.w3_%0d", k), 8'h40 + 8'(k), 2'd3, k == 3);
      end
      bus.grant = 4'b0000;
      bus.valid = 4'b0000;
      tick;

      // Malformed grant
      bus.grant = 4'b0101;
      bus.valid = 4'b0101;
      #1;
      check("t4.rdy0", 32'(bus.rdy), 32'h0);
      tick;
      flags("t4.err", 4'b0001);
      check("t4.rdy1", 32'(bus.rdy), 32'h0);
      bus.grant = 4'b0000;
      bus.valid = 4'b0000;
      tick;
      flags("t4.clr", 4'b0000);
      check("t4.rdy2", 32'(bus.rdy), 32'h0);

      // Reset after the second word, then a fresh full burst
      bus.grant = 4'b0010;
      bus.valid = 4'b0010;
      set_lane(1, 8'h50);
      tick;
      tick;
      word("t5.w0", 8'h50, 2'd1, 1'b0);
      set_lane(1, 8'h51);
      tick;
      word("t5.w1", 8'h51, 2'd1, 1'b0);
      sclr_n = 1'b0;
      tick;
      check("t5.rst_dout", 32'(bus.dout), 32'h0);
      check("t5.rst_src", 32'(bus.dout_src), 32'h0);
      flags("t5.rst", 4'b0000);
      check("t5.rst_rdy", 32'(bus.rdy), 32'h0);
      sclr_n = 1'b1;
      tick;
      check("t5.rdy_xfer", 32'(bus.rdy), 32'h2);
      for (int k = 0; k < 4; k++) begin
         set_lane(1, 8'h60 + 8'(k));
         tick;
         word($sformatf("t5.w2_%0d", k), 8'h60 + 8'(k), 2'd1, k == 3);
      end
      bus.grant = 4'b0000;
      bus.valid = 4'b0000;
      tick;

      // Rotating grants with BURST_LEN=2, arbiter reacting to ack a cycle later
      bus2.valid = 4'b1111;
      bus2.din   = 32'hA3A2A1A0;
      bus2.grant = 4'b0001;
      r    = 0;
      pend = 1'b0;
      nlog = 0;
      #1;
      check("t6.dec_oh0", 32'(chk_onehot), 32'h1);
      check("t6.dec_idx0", 32'(chk_idx), 32'h0);
      for (int cyc = 0; cyc < 60 && r < 4; cyc++) begin
         tick;
         if (pend) begin
            r++;
            bus2.grant = (r < 4) ? 4'(1 << r) : 4'b0000;
            pend = 1'b0;
         end
         if (bus2.dout_valid) begin
            if (nlog < 8) src_log[nlog] = bus2.dout_src;
            nlog++;
         end
         if (bus2.ack) pend = 1'b1;
      end
      check("t6.rotations", 32'(r), 32'd4);
      check("t6.nwords", 32'(nlog), 32'd8);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("t6.src%0d", i), 32'(src_log[i]), 32'(i / 2));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
